// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: fixed-latency mult/div with pending result, HI/LO commit and pipeline stall.
// Busy MULT_CYCLES/DIV_CYCLES cycles after start; new requests are ignored while busy, stall backpressures D-stage.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [1:0]  hilo_wr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Division runs on magnitudes so 0x80000000 / -1 and sign rules fall out naturally.
  always_comb begin
    prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u     = {32'b0, rs_val} * {32'b0, rt_val};
    div_signed = ~md_op[0];
    a_neg      = div_signed & rs_val[31];
    b_neg      = div_signed & rt_val[31];
    a_mag      = a_neg ? -rs_val : rs_val;
    b_mag      = b_neg ? -rt_val : rt_val;
    b_safe     = (rt_val == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_op[1]) begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_wr_d = (rt_val != 32'd0);
            cnt_d     = DIV_LOAD;
            state_d   = DIV;
          end else begin
            pend_hi_d = md_op[0] ? prod_u[63:32] : prod_s[63:32];
            pend_lo_d = md_op[0] ? prod_u[31:0]  : prod_s[31:0];
            pend_wr_d = 1'b1;
            cnt_d     = MULT_LOAD;
            state_d   = MULT;
          end
        end else if (hilo_wr == 2'b01) begin
          hi_d = rs_val;
        end else if (hilo_wr == 2'b10) begin
          lo_d = rs_val;
        end
      end
      MULT, DIV: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall = reset & d_uses_md & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: fixed vectors, HI/LO moves, reset abort and random ops.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [1:0]  hilo_wr;
  logic [31:0] rs_val, rt_val;
  logic        d_uses_md;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;
  exp_t scoreboard[$];

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .hilo_wr(hilo_wr),
    .rs_val(rs_val), .rt_val(rt_val), .d_uses_md(d_uses_md),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_md(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input logic [1:0] wr_start, input logic [1:0] wr_during, input bit rel_rst);
    exp_t e;
    logic [31:0] phi, plo;
    int nbusy, ndone, done_at;
    bit held, stall_ok;
    @(negedge clk);
    if (rel_rst) reset = 1'b1;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; hilo_wr = wr_start;
    e.hi = ehi; e.lo = elo; e.cycles = ecyc;
    scoreboard.push_back(e);
    phi = hi; plo = lo;
    #1;
    checks++;
    if (stall !== d_uses_md) begin errors++; $display("FAIL %s stall_at_start: got %b want %b", name, stall, d_uses_md); end
    nbusy = 0; ndone = 0; done_at = 0; held = 1; stall_ok = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2 && wr_during != 2'b00) begin
        start = 1'b1; md_op = ~op; hilo_wr = wr_during; rs_val = 32'h5555AAAA;
      end else begin
        start = 1'b0; hilo_wr = 2'b00;
      end
      #1;
      if (!busy) break;
      nbusy++;
      if (done) begin ndone++; done_at = c; end
      if (hi !== phi || lo !== plo) held = 0;
      if (stall !== d_uses_md) stall_ok = 0;
    end
    start = 1'b0; hilo_wr = 2'b00;
    e = scoreboard.pop_front();
    checks++;
    if (nbusy != e.cycles) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, nbusy, e.cycles); end
    checks++;
    if (ndone != 1 || done_at != e.cycles) begin errors++; $display("FAIL %s done_pulse: got %0d pulses at %0d want 1 at %0d", name, ndone, done_at, e.cycles); end
    checks++;
    if (!held) begin errors++; $display("FAIL %s hilo_held_while_busy: got changed want %h/%h", name, phi, plo); end
    checks++;
    if (!stall_ok) begin errors++; $display("FAIL %s stall_while_busy: got mismatch want %b", name, d_uses_md); end
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s idle_after: got stall=%b done=%b want 0/0", name, stall, done); end
    checks++;
    if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, e.hi); end
    checks++;
    if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, e.lo); end
  endtask

  task automatic hilo_write(input string name, input logic [1:0] wr, input logic [31:0] val,
                            input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    hilo_wr = wr; rs_val = val;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_during: got %b want 0", name, busy); end
    @(negedge clk);
    hilo_wr = 2'b00;
    #1;
    checks++;
    if (hi !== ehi || lo !== elo) begin errors++; $display("FAIL %s hilo: got %h/%h want %h/%h", name, hi, lo, ehi, elo); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s no_busy_done: got %b/%b want 0/0", name, busy, done); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; md_op = 2'b00; hilo_wr = 2'b00;
    rs_val = 32'h0; rt_val = 32'h0; d_uses_md = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b want 0/0/0", busy, done, stall);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    start = 1'b0; d_uses_md = 1'b0; reset = 1'b1;
  endtask

  task automatic test_mult();
    d_uses_md = 1'b1;
    do_md("mult", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 2'b00, 2'b00, 0);
    d_uses_md = 1'b0;
    do_md("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, 2'b00, 2'b00, 0);
  endtask

  task automatic test_div();
    do_md("div", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 2'b00, 2'b00, 0);
    do_md("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 2'b00, 2'b00, 0);
    hilo_write("mthi", 2'b01, 32'h11, 32'h11, 32'h80000000);
    hilo_write("mtlo", 2'b10, 32'h22, 32'h11, 32'h22);
    do_md("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h11, 32'h22, 10, 2'b00, 2'b00, 0);
    do_md("div_zero", 2'b10, 32'h1234, 32'h0, 32'h11, 32'h22, 10, 2'b00, 2'b00, 0);
  endtask

  task automatic test_hilo_moves();
    hilo_write("mtlo_abcd", 2'b10, 32'hABCD, 32'h11, 32'hABCD);
    hilo_write("reserved", 2'b11, 32'hDEAD, 32'h11, 32'hABCD);
  endtask

  task automatic test_precedence_and_ignore();
    do_md("start_over_mthi", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 2'b01, 2'b00, 0);
    do_md("ignore_busy", 2'b01, 32'd7, 32'd6, 32'h0, 32'd42, 5, 2'b00, 2'b10, 0);
    do_md("ignore_busy_div", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 2'b00, 2'b01, 0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    longint      p;
    longint unsigned pu;
    int          sa, sbv;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd5;
      if (a == 32'h80000000) a = 32'h7FFFFFFF;
      case (op)
        2'b00: begin
          sa = a; sbv = b; p = longint'(sa) * longint'(sbv);
          ehi = p[63:32]; elo = p[31:0];
        end
        2'b01: begin
          pu = longint'({32'b0, a}) * longint'({32'b0, b});
          ehi = pu[63:32]; elo = pu[31:0];
        end
        2'b10: begin
          sa = a; sbv = b; elo = sa / sbv; ehi = sa % sbv;
        end
        default: begin
          elo = a / b; ehi = a % b;
        end
      endcase
      do_md("random", op, a, b, ehi, elo, op[1] ? 10 : 5, 2'b00, 2'b00, 0);
    end
  endtask

  task automatic test_reset_abort();
    bit stall_ok;
    int ndone;
    d_uses_md = 1'b1;
    stall_ok = 1;
    @(negedge clk);
    start = 1'b1; md_op = 2'b00; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
    #1;
    if (stall !== 1'b1) stall_ok = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 0;
    end
    checks++;
    if (!stall_ok) begin errors++; $display("FAIL abort_stall_cycles_0_2: got not all 1 want 1"); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: got stall=%b busy=%b done=%b want 0/0/0", stall, busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_commit: got done=%0d hi=%h lo=%h busy=%b want 0/0/0/0", ndone, hi, lo, busy);
    end
    d_uses_md = 1'b0;
  endtask

  task automatic test_start_after_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_md("start_at_release", 2'b01, 32'd9, 32'd9, 32'h0, 32'd81, 5, 2'b00, 2'b00, 1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_hilo_moves();
    test_precedence_and_ignore();
    test_random();
    test_reset_abort();
    test_start_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage MD instruction valid, one cycle per instruction.
REQ-006 SHALL have port md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port hilo_wr  input  2  00 none, 01 mthi, 10 mtlo, 11 reserved (ignored).
REQ-008 SHALL have port rs_val  input  32  E-stage forwarded rs operand.
REQ-009 SHALL have port rt_val  input  32  E-stage forwarded rt operand.
REQ-010 SHALL have port d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port stall  output  1  freeze PC and F/D register, bubble into E.
REQ-013 SHALL have port done  output  1  one-cycle pulse on the HI/LO commit.
REQ-014 SHALL have port hi  output  32  architectural HI.
REQ-015 SHALL have port lo  output  32  architectural LO.

Function
REQ-016 SHALL implement states IDLE, MULT, DIV with a 4-bit down-counter.
REQ-017 SHALL, in IDLE with start=1, latch the full result into pending registers and load the counter.
- Load value: MULT_CYCLES-1 for md_op[1]=0, then enter MULT.
- Load value: DIV_CYCLES-1 for md_op[1]=1, then enter DIV.
REQ-018 SHALL hold busy=1 in MULT/DIV and busy=0 in IDLE, giving exactly MULT_CYCLES/DIV_CYCLES busy cycles starting the cycle after start.
REQ-019 SHALL decrement the counter each cycle in MULT/DIV, and on the cycle it reads 0:
- write the pending value to hi/lo
- pulse done=1
- return to IDLE.
REQ-020 SHALL compute mult as a signed 64-bit product and multu as an unsigned 64-bit product, with hi=[63:32] and lo=[31:0].
REQ-021 SHALL compute div/divu as lo=quotient and hi=remainder.
- Signed: quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-022 SHALL, on division by zero, still run DIV_CYCLES busy cycles and leave hi/lo unchanged, with done still pulsing.
REQ-023 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0.
REQ-024 SHALL, in IDLE with start=0, write rs_val to hi (hilo_wr=01) or lo (hilo_wr=10) at the next edge, with no busy and no done.
REQ-025 SHALL give start precedence over hilo_wr when both are asserted in IDLE, ignoring hilo_wr.
REQ-026 SHALL ignore start and hilo_wr while busy=1, leaving state, counter and pending registers unchanged.
REQ-027 SHALL drive stall = d_uses_md AND (busy OR start), combinationally.
REQ-028 SHALL keep stall asserted on the commit cycle and release it the cycle after the return to IDLE.
REQ-029 SHALL drive hi/lo only from registers, never from pending values.

Reset
REQ-030 SHALL, while reset=0, asynchronously force IDLE, counter=0, hi=0, lo=0, pending=0, busy=0 and done=0, and hold stall=0.
REQ-031 SHALL, if reset asserts mid-operation, abort the operation and commit nothing.
REQ-032 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL check mult: rs=0xFFFFFFFE, rt=3, start -> busy for 5 cycles, done on the 5th, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-034 SHALL check multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 SHALL check div: rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-036 SHALL check a divu by zero with prior hi=0x11, lo=0x22 -> 10 busy cycles, done pulses, hi=0x11 and lo=0x22 retained.
REQ-037 SHALL check mtlo rs=0xABCD in IDLE -> lo=0xABCD the next cycle, busy=0 throughout.
REQ-038 SHALL check start mult with d_uses_md held at 1 and reset=0 pulsed in cycle 3 -> stall=1 in cycles 0-2, then IDLE, hi=lo=0, no done pulse.
